defunnel_dat_pipe: RTL and testbench
====================================

DEFUNNEL_DAT_PIPE -- requirements
Module: defunnel_dat_pipe

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- W, 128, lane width in bits
- IN_LANES, 4, input lanes per beat (power of 2)
- OUT_SLOTS, 8, output slots per word (power of 2, >= IN_LANES)
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- t_dat  in  IN_LANES*W  input lanes; lane k = bits [k*W +: W]
- t_valid  in  1  input beat valid
- t_last  in  1  beat closes the current word early
- t_ready  out  1  input beat accepted when t_valid && t_ready
- t_cfg_dat  in  8  config; [1:0] = log2 R, where R = lanes consumed per beat
- mode  out  8  config latched for the current word
- i_0_dat  out  OUT_SLOTS*W  assembled word; slot s = bits [s*W +: W]
- i_valid  out  1  word valid
- i_last  out  1  word was closed by t_last
- i_ready  in  1  word consumed when i_valid && i_ready
REQ-003 The block SHALL use one clock (clk) with a synchronous, active-high reset (reset); the polarity and synchronicity are fixed.

Function
REQ-004 Effective R SHALL be 2^t_cfg_dat[1:0], clamped to IN_LANES when it is larger.
REQ-005 Config latching:
- mode SHALL load t_cfg_dat on an accepted beat when fill pointer == 0 and no word is pending.
- That same beat SHALL use the new config.
- Config changes at any other time SHALL be ignored until the next word start.
REQ-006 Beat write: each accepted beat SHALL write t_dat lanes 0..R-1 into assembly slots ptr..ptr+R-1, then advance ptr by R.
REQ-007 Completion: a word SHALL complete on the accepted beat where ptr+R == OUT_SLOTS or t_last == 1.
- On completion, ptr SHALL return to 0.
- Slots >= final ptr SHALL be zero in the emitted word.
REQ-008 Direct path: if the output register is free on a completing beat (!i_valid || i_ready), i_0_dat/i_last SHALL load the completed word (including that beat's lanes) and i_valid SHALL be 1 in the next cycle.
- Latency: 1 cycle from completing beat to i_valid.
REQ-009 Pending path: if the output register is not free, the completed word SHALL be held in the assembly buffer with flag cmp_q = 1.
- While cmp_q == 1, t_ready SHALL be 0.
- In the first cycle the output register is free, the held word SHALL transfer to the output register and cmp_q SHALL clear.
REQ-010 t_ready SHALL equal !cmp_q and SHALL be registered-source only (no combinational path from t_valid, t_last or i_ready).
REQ-011 i_valid SHALL clear after a handshake unless a new word loads in the same cycle; back-to-back words SHALL sustain one word per OUT_SLOTS/R beats with no bubble when i_ready == 1.
REQ-012 While i_valid == 1 && i_ready == 0, i_0_dat, i_last and i_valid SHALL hold stable.
REQ-013 t_last on a beat that also fills the word SHALL produce one word with i_last = 1, not two.

Reset
REQ-014 While reset == 1 at a clk edge, the following SHALL take effect:
- ptr = 0, cmp_q = 0, i_valid = 0, i_last = 0, i_0_dat = 0, mode = 0.
- The assembly buffer contents SHALL be discarded.
- t_ready SHALL be 1 in the first cycle after reset.
- Reset mid-word SHALL discard the partial word with no output.

Verification
REQ-015 The bench SHALL cover these scenarios (defaults, i_ready = 1 unless stated; lanes written as letters):
- cfg = 2 (R = 4), beats {A,B,C,D}, {E,H,G,H'}: i_valid = 1 one cycle after beat 2, slots 0..7 = A,B,C,D,E,H,G,H', i_last = 0, mode = 2.
- cfg = 0 (R = 1), 8 beats with lane0 = 1..8: slots 0..7 = 1..8; lanes 1..3 ignored.
- cfg = 1 (R = 2), 3 beats, t_last on beat 3 with lanes {1,2},{3,4},{5,6}: slots = 1,2,3,4,5,6,0,0, i_last = 1.
- Backpressure, cfg = 2, i_ready = 0, 4 beats:
  - word 1 in the output register; word 2 completes and cmp_q = 1, t_ready = 0.
  - Set i_ready = 1 for one cycle: word 1 consumed, word 2 appears next cycle, t_ready returns to 1.
- Reset after 1 beat of an R = 4 word: no i_valid; the next 2 beats form a clean word; mode reflects the new cfg.
- cfg = 3 (R = 8 > IN_LANES): behaves as R = 4 (2 beats per word); cfg changed mid-word: ignored until the next word.

Source files
------------

// File: rtl/defunnel_dat_pipe.sv
// Defunnel: packs R lanes per input beat into an OUT_SLOTS-wide word.
// Has a one-word output register and can hold one completed word in the assembly buffer.
module defunnel_dat_pipe #(
  parameter int W         = 128,
  parameter int IN_LANES  = 4,
  parameter int OUT_SLOTS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IN_LANES*W-1:0]  t_dat,
  input  logic                   t_valid,
  input  logic                   t_last,
  output logic                   t_ready,
  input  logic [7:0]             t_cfg_dat,
  output logic [7:0]             mode,
  output logic [OUT_SLOTS*W-1:0] i_0_dat,
  output logic                   i_valid,
  output logic                   i_last,
  input  logic                   i_ready
);

  localparam int PW = $clog2(OUT_SLOTS) + 1;

  logic [PW-1:0]          ptr_q, ptr_d;
  logic [OUT_SLOTS*W-1:0] buf_q, buf_d;
  logic [OUT_SLOTS*W-1:0] dat_q, dat_d;
  logic [OUT_SLOTS*W-1:0] asm_word;
  logic [7:0]             mode_q, mode_d;
  logic                   cmp_q, cmp_d;
  logic                   pend_last_q, pend_last_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;

  logic       word_start;
  logic       accept;
  logic       out_free;
  logic       complete;
  logic [7:0] cfg_sel;
  int         r_eff;
  int         ptr_i;

  // The first beat of a word uses the incoming config; later beats use the latched one.
  always_comb begin
    word_start = (ptr_q == '0) && !cmp_q;
    cfg_sel    = word_start ? t_cfg_dat : mode_q;
    r_eff      = 1 << cfg_sel[1:0];
    if (r_eff > IN_LANES) begin
      r_eff = IN_LANES;
    end
    ptr_i    = int'(ptr_q);
    accept   = t_valid && !cmp_q;
    out_free = !valid_q || i_ready;
    complete = accept && ((ptr_i + r_eff >= OUT_SLOTS) || t_last);
  end

  // A word start builds on an all-zero base, so slots beyond the final pointer stay zero.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_SLOTS; gi++) begin : g_slot
      logic [W-1:0] slot_val;
      always_comb begin
        slot_val = word_start ? '0 : buf_q[gi*W +: W];
        for (int j = 0; j < IN_LANES; j++) begin
          if ((j < r_eff) && (ptr_i + j == gi)) begin
            slot_val = t_dat[j*W +: W];
          end
        end
      end
      assign asm_word[gi*W +: W] = slot_val;
    end
  endgenerate

  always_comb begin
    ptr_d       = ptr_q;
    buf_d       = buf_q;
    dat_d       = dat_q;
    mode_d      = mode_q;
    cmp_d       = cmp_q;
    pend_last_d = pend_last_q;
    valid_d     = valid_q;
    last_d      = last_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (cmp_q && out_free) begin
      dat_d   = buf_q;
      last_d  = pend_last_q;
      valid_d = 1'b1;
      cmp_d   = 1'b0;
    end

    if (accept) begin
      if (word_start) begin
        mode_d = t_cfg_dat;
      end
      buf_d = asm_word;
      if (complete) begin
        ptr_d = '0;
        if (out_free) begin
          dat_d   = asm_word;
          last_d  = t_last;
          valid_d = 1'b1;
        end else begin
          cmp_d       = 1'b1;
          pend_last_d = t_last;
        end
      end else begin
        ptr_d = PW'(ptr_i + r_eff);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      buf_q       <= '0;
      dat_q       <= '0;
      mode_q      <= '0;
      cmp_q       <= 1'b0;
      pend_last_q <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      buf_q       <= buf_d;
      dat_q       <= dat_d;
      mode_q      <= mode_d;
      cmp_q       <= cmp_d;
      pend_last_q <= pend_last_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  assign t_ready = !cmp_q;
  assign mode    = mode_q;
  assign i_0_dat = dat_q;
  assign i_valid = valid_q;
  assign i_last  = last_q;

endmodule

// File: tb/tb_defunnel_dat_pipe.sv
// Directed bench for defunnel_dat_pipe: a table of single-beat vectors plus
// hand-written backpressure and mid-word reset sequences.
module tb_defunnel_dat_pipe;

  localparam int W         = 128;
  localparam int IN_LANES  = 4;
  localparam int OUT_SLOTS = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [IN_LANES*W-1:0]  t_dat;
  logic                   t_valid;
  logic                   t_last;
  logic                   t_ready;
  logic [7:0]             t_cfg_dat;
  logic [7:0]             mode;
  logic [OUT_SLOTS*W-1:0] i_0_dat;
  logic                   i_valid;
  logic                   i_last;
  logic                   i_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  defunnel_dat_pipe #(.W(W), .IN_LANES(IN_LANES), .OUT_SLOTS(OUT_SLOTS)) dut (
    .clk      (clk),
    .reset    (reset),
    .t_dat    (t_dat),
    .t_valid  (t_valid),
    .t_last   (t_last),
    .t_ready  (t_ready),
    .t_cfg_dat(t_cfg_dat),
    .mode     (mode),
    .i_0_dat  (i_0_dat),
    .i_valid  (i_valid),
    .i_last   (i_last),
    .i_ready  (i_ready)
  );

  typedef struct {
    logic              v;
    logic [7:0]        cfg;
    logic              last;
    logic [0:3][15:0]  lanes;
    logic              exp_valid;
    logic [0:7][15:0]  exp_slots;
    logic              exp_last;
    logic [7:0]        exp_mode;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] slot(input int s);
    return i_0_dat[s*W +: W];
  endfunction

  // Drive one cycle at the falling edge, then sample just after the rising edge.
  task automatic drive(input logic v, input logic [7:0] cfg, input logic last,
                       input logic [0:3][15:0] ln);
    @(negedge clk);
    t_valid   = v;
    t_cfg_dat = cfg;
    t_last    = last;
    for (int k = 0; k < IN_LANES; k++) t_dat[k*W +: W] = W'(ln[k]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:7][15:0] s2;
    reset = 1'b1; t_valid = 1'b0; t_last = 1'b0; t_cfg_dat = '0; t_dat = '0; i_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid", W'(i_valid), W'(0));
    check("rst_last",  W'(i_last),  W'(0));
    check("rst_ready", W'(t_ready), W'(1));
    check("rst_mode",  W'(mode),    W'(0));
    check("rst_dat0",  slot(0),     W'(0));

    // cfg=2: two beats form one word
    vq.push_back('{1'b1, 8'd2, 1'b0, {16'hA, 16'hB, 16'hC, 16'hD}, 1'b0, '0, 1'b0, 8'd0});
    vq.push_back('{1'b1, 8'd2, 1'b0, {16'hE, 16'h48, 16'h47, 16'h49}, 1'b1,
                   {16'hA, 16'hB, 16'hC, 16'hD, 16'hE, 16'h48, 16'h47, 16'h49}, 1'b0, 8'd2});
    // cfg=0: one lane per beat, upper lanes ignored
    s2 = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    for (int k = 1; k <= 8; k++)
      vq.push_back('{1'b1, 8'd0, 1'b0, {16'(k), 16'hFF, 16'hFF, 16'hFF}, (k == 8),
                     ((k == 8) ? s2 : '0), 1'b0, 8'd0});
    // cfg=1: early close with t_last, tail slots zero
    vq.push_back('{1'b1, 8'd1, 1'b0, {16'd1, 16'd2, 16'hEE, 16'hEE}, 1'b0, '0, 1'b0, 8'd0});
    vq.push_back('{1'b1, 8'd1, 1'b0, {16'd3, 16'd4, 16'hEE, 16'hEE}, 1'b0, '0, 1'b0, 8'd0});
    vq.push_back('{1'b1, 8'd1, 1'b1, {16'd5, 16'd6, 16'hEE, 16'hEE}, 1'b1,
                   {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0, 16'd0}, 1'b1, 8'd1});
    // cfg=3 clamps to R=4; mid-word change to cfg=0 ignored, applies to the next word
    vq.push_back('{1'b1, 8'd3, 1'b0, {16'h31, 16'h32, 16'h33, 16'h34}, 1'b0, '0, 1'b0, 8'd0});
    vq.push_back('{1'b1, 8'd0, 1'b0, {16'h35, 16'h36, 16'h37, 16'h38}, 1'b1,
                   {16'h31, 16'h32, 16'h33, 16'h34, 16'h35, 16'h36, 16'h37, 16'h38}, 1'b0, 8'd3});
    vq.push_back('{1'b1, 8'd0, 1'b1, {16'h77, 16'hEE, 16'hEE, 16'hEE}, 1'b1,
                   {16'h77, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 1'b1, 8'd0});
    // t_last on the filling beat yields exactly one word
    vq.push_back('{1'b1, 8'd2, 1'b0, {16'h41, 16'h42, 16'h43, 16'h44}, 1'b0, '0, 1'b0, 8'd0});
    vq.push_back('{1'b1, 8'd2, 1'b1, {16'h45, 16'h46, 16'h47, 16'h48}, 1'b1,
                   {16'h41, 16'h42, 16'h43, 16'h44, 16'h45, 16'h46, 16'h47, 16'h48}, 1'b1, 8'd2});
    vq.push_back('{1'b0, 8'd0, 1'b0, '0, 1'b0, '0, 1'b0, 8'd0});

    foreach (vq[n]) begin
      drive(vq[n].v, vq[n].cfg, vq[n].last, vq[n].lanes);
      check($sformatf("v%0d_ready", n), W'(t_ready), W'(1));
      check($sformatf("v%0d_valid", n), W'(i_valid), W'(vq[n].exp_valid));
      if (vq[n].exp_valid) begin
        for (int s = 0; s < OUT_SLOTS; s++)
          check($sformatf("v%0d_slot%0d", n, s), slot(s), W'(vq[n].exp_slots[s]));
        check($sformatf("v%0d_last", n), W'(i_last), W'(vq[n].exp_last));
        check($sformatf("v%0d_mode", n), W'(mode),   W'(vq[n].exp_mode));
      end
      $display("vec %0d: v=%0b cfg=%0d last=%0b -> i_valid=%0b i_last=%0b mode=%0d",
               n, vq[n].v, vq[n].cfg, vq[n].last, i_valid, i_last, mode);
    end

    // Backpressure: word 1 parked in output, word 2 held pending
    @(negedge clk); i_ready = 1'b0;
    drive(1'b1, 8'd2, 1'b0, {16'd1, 16'd2, 16'd3, 16'd4});
    drive(1'b1, 8'd2, 1'b0, {16'd5, 16'd6, 16'd7, 16'd8});
    check("bp_w1_valid", W'(i_valid), W'(1));
    check("bp_w1_s7",    slot(7),     W'(8));
    drive(1'b1, 8'd2, 1'b0, {16'h11, 16'h12, 16'h13, 16'h14});
    check("bp_b3_ready", W'(t_ready), W'(1));
    drive(1'b1, 8'd2, 1'b0, {16'h15, 16'h16, 16'h17, 16'h18});
    check("bp_b4_ready", W'(t_ready), W'(0));
    check("bp_b4_valid", W'(i_valid), W'(1));
    check("bp_b4_s0",    slot(0),     W'(1));
    drive(1'b1, 8'd2, 1'b0, {16'h99, 16'h99, 16'h99, 16'h99});
    check("bp_hold_ready", W'(t_ready), W'(0));
    check("bp_hold_s4",    slot(4),     W'(5));
    $display("bp: word1 held, pending word2, t_ready=%0b", t_ready);
    @(negedge clk); t_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_w2_valid", W'(i_valid), W'(1));
    check("bp_w2_s0",    slot(0),     W'(16'h11));
    check("bp_w2_s7",    slot(7),     W'(16'h18));
    check("bp_w2_ready", W'(t_ready), W'(1));
    check("bp_w2_last",  W'(i_last),  W'(0));
    @(negedge clk); i_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_w2_stable", slot(3), W'(16'h14));
    @(negedge clk); i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drain_valid", W'(i_valid), W'(0));
    $display("bp: word2 consumed, i_valid=%0b", i_valid);

    // Reset mid-word discards the partial word
    drive(1'b1, 8'd2, 1'b0, {16'h51, 16'h52, 16'h53, 16'h54});
    @(negedge clk); t_valid = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    check("mr_valid", W'(i_valid), W'(0));
    check("mr_ready", W'(t_ready), W'(1));
    check("mr_mode",  W'(mode),    W'(0));
    drive(1'b1, 8'd3, 1'b0, {16'h61, 16'h62, 16'h63, 16'h64});
    check("mr_b1_valid", W'(i_valid), W'(0));
    drive(1'b1, 8'd0, 1'b0, {16'h65, 16'h66, 16'h67, 16'h68});
    check("mr_w_valid", W'(i_valid), W'(1));
    check("mr_w_s0",    slot(0),     W'(16'h61));
    check("mr_w_s4",    slot(4),     W'(16'h65));
    check("mr_w_s7",    slot(7),     W'(16'h68));
    check("mr_w_mode",  W'(mode),    W'(3));
    $display("reset-mid-word: new word valid=%0b mode=%0d", i_valid, mode);
    drive(1'b0, 8'd0, 1'b0, '0);
    check("mr_end_valid", W'(i_valid), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
